// File: rtl/la_iopoc_pkg.sv
// Shared constants for the pad-ring power-on sequencer: state codes,
// ioring bit positions and the per-state ring pattern.
package la_iopoc_pkg;

  // FSM state codes; code 7 is unused and recovers to ST_OFF.
  localparam logic [2:0] ST_OFF    = 3'd0;
  localparam logic [2:0] ST_PWRUP  = 3'd1;
  localparam logic [2:0] ST_ISOREL = 3'd2;
  localparam logic [2:0] ST_ON     = 3'd3;
  localparam logic [2:0] ST_DRVOFF = 3'd4;
  localparam logic [2:0] ST_ISOSET = 3'd5;
  localparam logic [2:0] ST_PWRDN  = 3'd6;

  // Bit positions inside the ioring bus.
  localparam int POC_EN = 0;
  localparam int ISO    = 1;
  localparam int RET    = 2;
  localparam int DRV_EN = 3;

  // Ring is isolated and unpowered out of reset.
  localparam logic [3:0] RING_RST = 4'b0010;

  // Low four ioring bits for a given state; ret only matters while OFF.
  function automatic logic [3:0] ring_bits(input logic [2:0] st, input logic ret);
    logic [3:0] r;
    r = 4'b0000;
    case (st)
      ST_OFF: begin
        r[ISO] = 1'b1;
        r[RET] = ret;
      end
      ST_PWRUP, ST_ISOSET, ST_PWRDN: begin
        r[POC_EN] = 1'b1;
        r[ISO]    = 1'b1;
      end
      ST_ISOREL, ST_DRVOFF: begin
        r[POC_EN] = 1'b1;
      end
      ST_ON: begin
        r[POC_EN] = 1'b1;
        r[DRV_EN] = 1'b1;
      end
      default: r = RING_RST;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/la_iopoc_dwell.sv
// Dwell counter: loads a delay on state entry and counts down to zero,
// holding at zero. zero is high in the last cycle of a dwell.
module la_iopoc_dwell #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] ld_val,
  output logic          zero
);

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] cnt;

  // Load has priority; otherwise decrement until zero and hold there.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= ld_val;
    end else if (cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/la_iopocseq.sv
// Power-on sequencer for the pad-ring POC cell. Steps the ring through
// POC enable -> isolation release -> driver enable and back, with
// programmable dwells, power-good loss handling and retention in OFF.
//
// Request interface: up_req and down_req are single-cycle pulses with no
// ack; a pulse is acted on only in the states where it is meaningful
// (up_req in OFF, down_req in ON/PWRUP/ISOREL) and is otherwise dropped.
// Completion is signalled by a one-cycle done pulse; busy covers the
// whole transient. ret_req is a level honoured only while OFF.
module la_iopocseq
  import la_iopoc_pkg::*;
#(
  parameter int RINGW = 8,
  parameter int CW    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwr_ok,
  input  logic             up_req,
  input  logic             down_req,
  input  logic             ret_req,
  input  logic [CW-1:0]    t_pwr,
  input  logic [CW-1:0]    t_iso,
  input  logic [CW-1:0]    t_drv,
  output logic [RINGW-1:0] ioring,
  output logic [2:0]       state,
  output logic             on,
  output logic             busy,
  output logic             done,
  output logic             fault
);

  logic [2:0]       nxt;
  logic             ld;
  logic [CW-1:0]    ld_val;
  logic             nxt_done;
  logic             pg_lost;
  logic             up_acc;
  logic             zero;
  logic [RINGW-1:0] ring_nxt;

  la_iopoc_dwell #(.CW(CW)) u_dwell (
    .clk    (clk),
    .reset  (reset),
    .load   (ld),
    .ld_val (ld_val),
    .zero   (zero)
  );

  assign pg_lost = (state != ST_OFF) && !pwr_ok;
  assign up_acc  = (state == ST_OFF) && up_req && pwr_ok && !down_req;

  // Next-state logic: power-good loss overrides everything, aborts beat
  // the dwell expiry, and each dwell state loads its successor's delay.
  always_comb begin
    nxt      = state;
    ld       = 1'b0;
    ld_val   = '0;
    nxt_done = 1'b0;
    if (pg_lost) begin
      nxt = ST_OFF;
    end else begin
      case (state)
        ST_OFF: begin
          if (up_acc) begin
            nxt = ST_PWRUP; ld = 1'b1; ld_val = t_pwr;
          end
        end
        ST_PWRUP: begin
          if (down_req) begin
            nxt = ST_ISOSET; ld = 1'b1; ld_val = t_iso;
          end else if (zero) begin
            nxt = ST_ISOREL; ld = 1'b1; ld_val = t_iso;
          end
        end
        ST_ISOREL: begin
          if (down_req) begin
            nxt = ST_ISOSET; ld = 1'b1; ld_val = t_iso;
          end else if (zero) begin
            nxt = ST_ON; nxt_done = 1'b1;
          end
        end
        ST_ON: begin
          if (down_req) begin
            nxt = ST_DRVOFF; ld = 1'b1; ld_val = t_drv;
          end
        end
        ST_DRVOFF: begin
          if (zero) begin
            nxt = ST_ISOSET; ld = 1'b1; ld_val = t_iso;
          end
        end
        ST_ISOSET: begin
          if (zero) begin
            nxt = ST_PWRDN; ld = 1'b1; ld_val = t_pwr;
          end
        end
        ST_PWRDN: begin
          if (zero) begin
            nxt = ST_OFF; nxt_done = 1'b1;
          end
        end
        default: nxt = ST_OFF;
      endcase
    end
  end

  // Ring pattern for the upcoming state, zero-extended to the bus width.
  always_comb begin
    ring_nxt      = '0;
    ring_nxt[3:0] = ring_bits(nxt, ret_req);
  end

  // Output registers are all driven from the next state so ioring moves
  // in the same cycle as the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_OFF;
      ioring <= {{(RINGW-4){1'b0}}, RING_RST};
      on     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      fault  <= 1'b0;
    end else begin
      state  <= nxt;
      ioring <= ring_nxt;
      on     <= (nxt == ST_ON);
      busy   <= (nxt != ST_OFF) && (nxt != ST_ON);
      done   <= nxt_done;
      if (pg_lost) begin
        fault <= 1'b1;
      end else if (up_acc) begin
        fault <= 1'b0;
      end
    end
  end

endmodule
